updown_counter_mod: RTL
=======================

# updown_counter_mod

Parametrised, loadable up/down counter with programmable modulus, variable step, enable, terminal-count and overflow/underflow flags. Next-generation replacement for the fixed 8-bit free-running up/down counter. Used as a general event/position counter in datapath and test designs, and as the standard DUT for the generated UVM environments. Single clock domain; all state registered.

## Interface
- `WIDTH`, 8: counter width in bits; must be 2 or greater.
- `MAX_VAL`, 2**WIDTH-1: counting range is 0..MAX_VAL inclusive; must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `STEP_W`, 4: width of the step input.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable.
- `up_dn` in 1: direction; 1 = up, 0 = down.
- `step` in STEP_W: increment/decrement amount per enabled cycle.
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value to load.
- `data_out` out WIDTH: registered count.
- `ovf` out 1: registered one-cycle pulse; up-count crossed MAX_VAL.
- `unf` out 1: registered one-cycle pulse; down-count crossed 0.
- `tc` out 1: combinational terminal count; (up_dn && data_out==MAX_VAL) || (!up_dn && data_out==0).
- `zero` out 1: combinational; data_out==0.

## Operation
- Priority per edge: reset > load > en > hold.
- Load: data_out <= min(load_val, MAX_VAL); ovf, unf <= 0; en, step and up_dn are ignored that cycle.
- Enabled, step==0: data_out holds; ovf, unf <= 0.
- Step values above MAX_VAL are reduced modulo (MAX_VAL+1) before use. The result is defined for all inputs.
- Up, s = reduced step, computed at WIDTH+1 bits, no truncation:
  - If data_out+s ≤ MAX_VAL: data_out <= data_out+s.
  - Otherwise wrap: data_out <= data_out+s-(MAX_VAL+1); ovf <= 1.
- Down:
  - If s ≤ data_out: data_out <= data_out-s.
  - Otherwise wrap: data_out <= data_out+(MAX_VAL+1)-s; unf <= 1.
- ovf and unf are never both 1. Both clear on any cycle that does not cross a boundary, including hold cycles (en=0).
- Internal arithmetic never depends on bits above WIDTH+1. When MAX_VAL = 2**WIDTH-1, behaviour equals plain modular arithmetic.

## Timing
- Reset values: data_out=0, ovf=0, unf=0, zero=1; tc = !up_dn.
- Reset asserts asynchronously mid-count: outputs go to reset values immediately, with no clock needed. Deassertion is synchronised externally; the first update is at the first rising edge with rst_n=1.
- Latency: one cycle from input sample to data_out/ovf/unf. tc and zero follow data_out and up_dn combinationally, with zero extra cycles.
- Simultaneous load and en: load wins; no flag pulse.
- Direction change takes effect on the same edge it is sampled; there is no turnaround cycle.

## Configuration
- `UDC_SATURATE_EN`:
  - Defined: boundary crossings saturate instead of wrapping.
    - Up overflow: data_out <= MAX_VAL.
    - Down underflow: data_out <= 0.
    - ovf/unf still pulse on the saturating cycle.
    - A further enabled cycle already at the limit in the same direction holds the value and pulses ovf/unf again.
  - Not defined: wrap behaviour as in Operation. This is the default.

## Test plan
All scenarios use WIDTH=8, MAX_VAL=9, STEP_W=4.
- Reset: rst_n=0 mid-count at data_out=5 → data_out=0, zero=1, ovf=unf=0 before the next clk edge. Release, en=0 for 3 cycles → data_out stays 0.
- Up wrap: data_out=8, up_dn=1, step=1, en for 3 cycles → 9 (tc=1), 0 with ovf=1, 1 with ovf=0.
- Down wrap, step 3: data_out=1, up_dn=0, step=3, en → data_out=8, unf=1. Next cycle → 5, unf=0.
- Load priority: load=1, load_val=0xC8, en=1, step=2 → data_out=9 (clamped), ovf=0. Next cycle up, step=2 → 1, ovf=1.
- Step edge cases: step=0, en=1 → hold, no flags. step=12 up from 0 → reduced to 2, data_out=2, no ovf.
- With UDC_SATURATE_EN: data_out=7, up, step=5 → 9, ovf=1. Repeat → 9, ovf=1. Down from 2, step=4 → 0, unf=1.

Source files
------------

// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
//
// Loadable up/down counter over the range 0..MAX_VAL with a variable step,
// count enable, terminal-count and zero indications, and one-cycle
// overflow/underflow pulses.
//
// Build option:
//   UDC_SATURATE_EN  - when defined, boundary crossings clamp to MAX_VAL / 0
//                      instead of wrapping; ovf/unf still pulse. Default off.
//
// Parameters:
//   WIDTH    counter width (>= 2)
//   MAX_VAL  top of counting range, 1 .. 2**WIDTH-1
//   STEP_W   width of the step input
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable
//   up_dn     in   1 = count up, 0 = count down
//   step      in   amount added/subtracted per enabled cycle
//   load      in   synchronous load (beats en)
//   load_val  in   value to load, clamped to MAX_VAL
//   data_out  out  registered count
//   ovf       out  registered pulse, up-count crossed MAX_VAL
//   unf       out  registered pulse, down-count crossed 0
//   tc        out  combinational terminal count for the current direction
//   zero      out  combinational data_out == 0
// -----------------------------------------------------------------------------
module updown_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  data_out,
    output logic              ovf,
    output logic              unf,
    output logic              tc,
    output logic              zero
);

    // One guard bit above the counter is enough for every sum/difference:
    // count <= MAX_VAL and reduced step <= MAX_VAL, so count+step fits.
    localparam int EW = WIDTH + 1;
    // Step reduction runs wide enough to hold either the raw step or the modulus.
    localparam int SW = (STEP_W > EW) ? STEP_W : EW;

    localparam logic [EW-1:0] MAXV = EW'(MAX_VAL);
    localparam logic [EW-1:0] MODV = MAXV + EW'(1);
    localparam logic [SW-1:0] MODS = SW'(MODV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [SW-1:0]    step_red;
    logic [EW-1:0]    s;
    logic [EW-1:0]    cnt_ext;
    logic [EW-1:0]    ld_ext;
    logic [EW-1:0]    sum;
    logic [EW-1:0]    nxt;
    logic             up_cross;
    logic             dn_cross;

    always_comb begin
        // Oversized steps are folded into range; the remainder always fits EW bits.
        step_red = SW'(step) % MODS;
        s        = EW'(step_red);
        cnt_ext  = {1'b0, cnt_q};
        ld_ext   = {1'b0, load_val};
        sum      = cnt_ext + s;
        up_cross = (sum > MAXV);
        dn_cross = (s > cnt_ext);

        nxt   = cnt_ext;
        ovf_d = 1'b0;
        unf_d = 1'b0;

        if (load) begin
            nxt = (ld_ext > MAXV) ? MAXV : ld_ext;
        end else if (en) begin
            if (up_dn) begin
                if (up_cross) begin
                    ovf_d = 1'b1;
`ifdef UDC_SATURATE_EN
                    nxt = MAXV;
`else
                    nxt = sum - MODV;
`endif
                end else begin
                    nxt = sum;
                end
            end else begin
                if (dn_cross) begin
                    unf_d = 1'b1;
`ifdef UDC_SATURATE_EN
                    nxt = '0;
`else
                    // Borrow one full modulus; result lands below MODV.
                    nxt = cnt_ext + MODV - s;
`endif
                end else begin
                    nxt = cnt_ext - s;
                end
            end
        end

        cnt_d = WIDTH'(nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign data_out = cnt_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign zero     = (cnt_q == '0);
    assign tc       = up_dn ? (cnt_ext == MAXV) : (cnt_q == '0);

endmodule
